sram_word_bridge: RTL and testbench

- Downstream stage of the LSU data-memory path.
- Converts one 32-bit word request (level-held read/write, byte mask) into two sequential 16-bit accesses on the off-chip 256Kx16 async SRAM.
- Returns a one-cycle o_ack plus the assembled 32-bit read data.
- Low halfword lives at the even SRAM address, high halfword at the odd address.

---
 rtl/sram_bridge_pkg.sv | 16 +
 rtl/sram_dq_pad.sv | 12 +
 rtl/sram_word_bridge.sv | 138 +++++++++++++
 tb/tb_sram_word_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// rtl/sram_bridge_pkg.sv - shared types and constants for the 32-to-16 bit SRAM word bridge
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_ACCESS_CYCLES = 2;

    localparam logic LO_SEL = 1'b0;
    localparam logic HI_SEL = 1'b1;

endpackage

// File: rtl/sram_dq_pad.sv
// rtl/sram_dq_pad.sv - tri-state driver for the 16-bit SRAM data bus
module sram_dq_pad (
    input  logic        oe,
    input  logic [15:0] wdata16,
    output logic [15:0] rdata16,
    inout  wire  [15:0] dq
);

    assign dq      = oe ? wdata16 : 16'bz;
    assign rdata16 = dq;

endmodule

// File: rtl/sram_word_bridge.sv
// rtl/sram_word_bridge.sv - 32-bit word request to two 16-bit async SRAM accesses; SRAM_BRIDGE_SKIP_EN skips fully masked write halves
module sram_word_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter int ADDR_W        = 18
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_bmask,
    input  logic              i_wren,
    input  logic              i_rden,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-2:0] word_q;
    logic [31:0]       wdata_q;
    logic [3:0]        bmask_q;
    logic              write_q;
    logic [15:0]       rd_lo_q;
    logic [31:0]       rdata_q;

    logic              req;
    logic              last;
    logic              active;
    logic              sel;
    logic [1:0]        half_mask;
    logic              dq_oe;
    logic [15:0]       dq_out;
    logic [15:0]       dq_in;
    logic              skip_lo_in;
    logic              skip_hi_in;
    logic              skip_hi_q;
    logic              unused_addr;

    assign unused_addr = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};

    assign req  = i_wren | i_rden;
    assign last = (cnt == CNT_LAST);

`ifdef SRAM_BRIDGE_SKIP_EN
    assign skip_lo_in = i_wren & (i_bmask[1:0] == 2'b00);
    assign skip_hi_in = i_wren & (i_bmask[3:2] == 2'b00);
    assign skip_hi_q  = write_q & (bmask_q[3:2] == 2'b00);
`else
    assign skip_lo_in = 1'b0;
    assign skip_hi_in = 1'b0;
    assign skip_hi_q  = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) state_nx = skip_lo_in ? (skip_hi_in ? DONE : HI) : LO;
            LO:   if (last) state_nx = skip_hi_q ? DONE : HI;
            HI:   if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            write_q <= 1'b0;
            rd_lo_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        word_q  <= i_addr[ADDR_W:2];
                        wdata_q <= i_wdata;
                        bmask_q <= i_bmask;
                        write_q <= i_wren;
                    end
                end
                LO: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last && !write_q) rd_lo_q <= dq_in;
                end
                HI: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    // Publish the whole word at once so o_rdata never shows a half-updated value
                    if (last && !write_q) rdata_q <= {dq_in, rd_lo_q};
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign active    = (state == LO) || (state == HI);
    assign sel       = (state == HI) ? HI_SEL : LO_SEL;
    assign half_mask = (sel == HI_SEL) ? bmask_q[3:2] : bmask_q[1:0];

    assign SRAM_ADDR = {word_q, sel};
    assign SRAM_CE_N = ~active;
    assign SRAM_WE_N = ~(active & write_q);
    assign SRAM_OE_N = ~(active & ~write_q);
    assign SRAM_LB_N = active ? (write_q ? ~half_mask[0] : 1'b0) : 1'b1;
    assign SRAM_UB_N = active ? (write_q ? ~half_mask[1] : 1'b0) : 1'b1;

    assign dq_oe  = active & write_q;
    assign dq_out = (sel == HI_SEL) ? wdata_q[31:16] : wdata_q[15:0];

    sram_dq_pad u_pad (
        .oe      (dq_oe),
        .wdata16 (dq_out),
        .rdata16 (dq_in),
        .dq      (SRAM_DQ)
    );

    assign o_ack   = (state == DONE);
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
// tb/tb_sram_word_bridge.sv - scoreboard bench for sram_word_bridge against a behavioural SRAM
module tb_sram_word_bridge;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        i_wren;
    logic        i_rden;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] sram_dq;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

    always #5 i_clk = ~i_clk;

    sram_word_bridge dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_bmask   (i_bmask),
        .i_wren    (i_wren),
        .i_rden    (i_rden),
        .o_rdata   (o_rdata),
        .o_ack     (o_ack),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_UB_N (SRAM_UB_N)
    );

    // Behavioural async SRAM, only the low 256 halfwords are exercised
    logic [15:0] mem [0:255];
    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    always @(posedge i_clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= sram_dq[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [37:0] trace[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: records bus phases and scores every ack against the queue
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!SRAM_CE_N)
            trace.push_back({SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N, sram_dq});
        if (o_ack) begin
            chk("done_strobes_idle",
                {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N, dut.dq_oe}, 6'b111110);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: actual=ack at cycle %0d required=no ack", cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_rdata", o_rdata, e.rdata);
                chk("ack_cycle", cyc, e.ack_cyc);
            end
        end
    end

    task automatic wait_ack();
        int n = 0;
        while (n < 40) begin
            @(negedge i_clk);
            if (o_ack) break;
            n++;
        end
        if (!o_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: actual=no ack in 40 cycles required=ack");
        end
    endtask

    task automatic run(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bm,
                       input logic [31:0] exp_rdata, input int lat);
        @(posedge i_clk);
        #1;
        i_wren  = wr;
        i_rden  = rd;
        i_addr  = addr;
        i_wdata = wdata;
        i_bmask = bm;
        sb.push_back('{exp_rdata, cyc + lat});
        wait_ack();
        @(posedge i_clk);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
    endtask

    task automatic expect_phases(input string name, input logic [17:0] a, input logic we_n,
                                 input logic oe_n, input logic lb_n, input logic ub_n,
                                 input logic [15:0] dq, input int n);
        for (int i = 0; i < n; i++) begin
            if (trace.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_missing: actual=no bus cycle required=bus cycle", name);
            end else begin
                chk(name, trace.pop_front(), {a, we_n, oe_n, lb_n, ub_n, dq});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        i_reset = 1'b1;
        i_wren  = 1'b0;
        i_rden  = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
        i_bmask = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'h1f);
        chk("reset_ack", o_ack, 0);
        chk("reset_rdata", o_rdata, 0);
        chk("reset_addr", SRAM_ADDR, 0);
        chk("reset_dq_hiz", dut.dq_oe, 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        trace.delete();

        // Full word write: word index 4 -> SRAM halfwords 8 and 9
        run(1, 0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 5);
        expect_phases("wr_lo", 18'h8, 0, 1, 0, 0, 16'hBEEF, 2);
        expect_phases("wr_hi", 18'h9, 0, 1, 0, 0, 16'hDEAD, 2);
        chk("wr_phase_count", trace.size(), 0);

        run(0, 1, 32'h2000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 5);
        expect_phases("rd_lo", 18'h8, 1, 0, 0, 0, 16'hBEEF, 2);
        expect_phases("rd_hi", 18'h9, 1, 0, 0, 0, 16'hDEAD, 2);
        chk("rd_phase_count", trace.size(), 0);

        // Byte-masked write into a preloaded word
        run(1, 0, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 5);
        trace.delete();
`ifdef SRAM_BRIDGE_SKIP_EN
        run(1, 0, 32'h0000_0020, 32'h00AA_0000, 4'b0100, 32'hDEAD_BEEF, 3);
`else
        run(1, 0, 32'h0000_0020, 32'h00AA_0000, 4'b0100, 32'hDEAD_BEEF, 5);
        expect_phases("bm_lo", 18'h10, 0, 1, 1, 1, 16'h0000, 2);
`endif
        expect_phases("bm_hi", 18'h11, 0, 1, 0, 1, 16'h00AA, 2);
        chk("bm_phase_count", trace.size(), 0);
        run(0, 1, 32'h0000_0020, 32'h0, 4'h0, 32'h11AA_3344, 5);
        trace.delete();

        // Write wins over simultaneous read; o_rdata keeps the last read word
        run(1, 1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 32'h11AA_3344, 5);
        expect_phases("both_lo", 18'h20, 0, 1, 0, 0, 16'hF00D, 2);
        expect_phases("both_hi", 18'h21, 0, 1, 0, 0, 16'h0BAD, 2);
        run(0, 1, 32'h0000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 5);
        trace.delete();

        // Write with no byte enabled leaves the SRAM untouched
`ifdef SRAM_BRIDGE_SKIP_EN
        run(1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0BAD_F00D, 1);
`else
        run(1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0BAD_F00D, 5);
        expect_phases("bm0_lo", 18'h20, 0, 1, 1, 1, 16'hFFFF, 2);
        expect_phases("bm0_hi", 18'h21, 0, 1, 1, 1, 16'hFFFF, 2);
`endif
        chk("bm0_phase_count", trace.size(), 0);
        run(0, 1, 32'h0000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 5);
        trace.delete();

        // Back-to-back reads with the request held; address change mid-access is ignored
        @(posedge i_clk);
        #1;
        i_rden = 1'b1;
        i_addr = 32'h2000_0010;
        sb.push_back('{32'hDEAD_BEEF, cyc + 5});
        sb.push_back('{32'h0BAD_F00D, cyc + 11});
        @(posedge i_clk);
        #1;
        i_addr = 32'h0000_0040;
        wait_ack();
        @(negedge i_clk);
        chk("b2b_idle_hiz", {dut.dq_oe, SRAM_WE_N, SRAM_CE_N}, 3'b011);
        wait_ack();
        @(posedge i_clk);
        #1;
        i_rden = 1'b0;
        trace.delete();

        // Reset during the HI half of a write aborts without an ack
        @(posedge i_clk);
        #1;
        i_wren  = 1'b1;
        i_addr  = 32'h0000_0060;
        i_wdata = 32'h1234_5678;
        i_bmask = 4'hF;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_in_hi", SRAM_ADDR, 18'h31);
        i_reset = 1'b1;
        i_wren  = 1'b0;
        @(posedge i_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("rst_mid_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'h1f);
            chk("rst_mid_dq_hiz", dut.dq_oe, 0);
            chk("rst_mid_no_ack", o_ack, 0);
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("rst_mid_rdata", o_rdata, 0);
        repeat (3) begin
            @(negedge i_clk);
            chk("post_rst_idle", {SRAM_CE_N, o_ack}, 2'b10);
        end
        trace.delete();

        run(0, 1, 32'h0000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 5);
        repeat (2) @(posedge i_clk);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
